// File: rtl/mem_dma_initiator.sv
// Word-copy engine acting as a mem_if initiator, one outstanding request at a time.
// Optional constant-fill mode is enabled by defining DMA_FILL_EN (adds fill_i/fill_data_i).

package urv_cfg;
  localparam int unsigned MEM_ADDR_W = 32;
  localparam int unsigned MEM_DATA_W = 32;
  localparam int unsigned MEM_MASK_W = MEM_DATA_W / 8;

  typedef enum logic {MEM_READ = 1'b0, MEM_WRITE = 1'b1} mem_type_e;

  typedef struct packed {
    logic [MEM_ADDR_W-1:0] req_addr;
    logic [MEM_DATA_W-1:0] req_data;
    logic [MEM_MASK_W-1:0] req_mask;
    mem_type_e             req_type;
  } mem_req_t;

  typedef struct packed {
    logic [MEM_DATA_W-1:0] resp_data;
    logic                  resp_last;
  } mem_resp_t;
endpackage

module mem_dma_initiator
  import urv_cfg::*;
#(
  parameter int unsigned LEN_W = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start_i,
  input  logic [MEM_ADDR_W-1:0] src_addr_i,
  input  logic [MEM_ADDR_W-1:0] dst_addr_i,
  input  logic [LEN_W-1:0]      len_i,
`ifdef DMA_FILL_EN
  input  logic                  fill_i,
  input  logic [MEM_DATA_W-1:0] fill_data_i,
`endif
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output mem_req_t              mem_req,
  input  logic                  mem_resp_valid,
  output logic                  mem_resp_ready,
  input  mem_resp_t             mem_resp
);

  localparam logic [MEM_ADDR_W-1:0] WORD_BYTES = MEM_ADDR_W'(MEM_DATA_W / 8);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_REQ, S_RD_RESP, S_WR_REQ, S_WR_RESP, S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [MEM_ADDR_W-1:0] src_q, src_d, dst_q, dst_d;
  logic [LEN_W-1:0]      cnt_q, cnt_d;
  logic [MEM_DATA_W-1:0] data_q, data_d;
  logic                  fill_q, fill_d;
  logic                  fill_start_c;
  logic [MEM_DATA_W-1:0] fill_data_c;

  logic                  busy_d, req_valid_d, resp_ready_d;
  mem_req_t              req_d;

  // One response per request, so the burst-end marker carries no information here.
  logic                  unused_resp_last;
  assign unused_resp_last = mem_resp.resp_last;

`ifdef DMA_FILL_EN
  assign fill_start_c = fill_i;
  assign fill_data_c  = fill_data_i;
`else
  assign fill_start_c = 1'b0;
  assign fill_data_c  = '0;
`endif

  // State, operand and output registers; outputs are decoded from the next state
  // so they line up with the state they describe.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q        <= S_IDLE;
      src_q          <= '0;
      dst_q          <= '0;
      cnt_q          <= '0;
      data_q         <= '0;
      fill_q         <= 1'b0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
      mem_req_valid  <= 1'b0;
      mem_resp_ready <= 1'b0;
      mem_req        <= '0;
    end else begin
      state_q        <= state_d;
      src_q          <= src_d;
      dst_q          <= dst_d;
      cnt_q          <= cnt_d;
      data_q         <= data_d;
      fill_q         <= fill_d;
      busy_o         <= busy_d;
      done_o         <= (state_q == S_DONE);
      mem_req_valid  <= req_valid_d;
      mem_resp_ready <= resp_ready_d;
      mem_req        <= req_d;
    end
  end

  // Next-state and operand update.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    fill_d  = fill_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          src_d  = src_addr_i;
          dst_d  = dst_addr_i;
          cnt_d  = len_i;
          fill_d = fill_start_c;
          if (fill_start_c) data_d = fill_data_c;
          if (len_i == '0)       state_d = S_DONE;
          else if (fill_start_c) state_d = S_WR_REQ;
          else                   state_d = S_RD_REQ;
        end
      end
      S_RD_REQ: if (mem_req_ready) state_d = S_RD_RESP;
      S_RD_RESP: begin
        if (mem_resp_valid) begin
          data_d  = mem_resp.resp_data;
          state_d = S_WR_REQ;
        end
      end
      S_WR_REQ: if (mem_req_ready) state_d = S_WR_RESP;
      S_WR_RESP: begin
        if (mem_resp_valid) begin
          src_d = src_q + WORD_BYTES;
          dst_d = dst_q + WORD_BYTES;
          cnt_d = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) state_d = S_DONE;
          else if (fill_q)        state_d = S_WR_REQ;
          else                    state_d = S_RD_REQ;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the upcoming state; request fields are zero when idle.
  always_comb begin
    busy_d       = (state_d != S_IDLE);
    req_valid_d  = 1'b0;
    resp_ready_d = 1'b0;
    req_d        = '0;
    case (state_d)
      S_RD_REQ: begin
        req_valid_d    = 1'b1;
        req_d.req_addr = src_d;
        req_d.req_type = MEM_READ;
      end
      S_WR_REQ: begin
        req_valid_d    = 1'b1;
        req_d.req_addr = dst_d;
        req_d.req_data = data_d;
        req_d.req_mask = '1;
        req_d.req_type = MEM_WRITE;
      end
      S_RD_RESP, S_WR_RESP: resp_ready_d = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_dma_initiator.sv
// Self-checking bench for mem_dma_initiator: table vectors, hand sequences and random copies
// against a word-level copy model, with a configurable-latency mem_if responder.
module tb_mem_dma_initiator;
  import urv_cfg::*;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start_i = 1'b0;
  logic [31:0] src_addr_i = '0;
  logic [31:0] dst_addr_i = '0;
  logic [15:0] len_i = '0;
`ifdef DMA_FILL_EN
  logic        fill_i = 1'b0;
  logic [31:0] fill_data_i = '0;
`endif
  logic        busy_o, done_o, mem_req_valid, mem_resp_ready;
  logic        mem_req_ready = 1'b0;
  logic        mem_resp_valid = 1'b0;
  mem_req_t    mem_req;
  mem_resp_t   mem_resp = '0;

  always #5 clk = ~clk;

  mem_dma_initiator dut (
    .clk(clk), .rstn(rstn), .start_i(start_i),
    .src_addr_i(src_addr_i), .dst_addr_i(dst_addr_i), .len_i(len_i),
`ifdef DMA_FILL_EN
    .fill_i(fill_i), .fill_data_i(fill_data_i),
`endif
    .busy_o(busy_o), .done_o(done_o),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req(mem_req),
    .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready), .mem_resp(mem_resp)
  );

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } txn_t;

  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    int          len;
    int          rw;
    int          sw;
    bit          spur;
    int          exp_lat;
  } vec_t;

  txn_t        log_q[$];
  txn_t        exp_q[$];
  logic [31:0] rsp_mem[logic [31:0]];
  logic [31:0] ref_mem[logic [31:0]];

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int req_wait = 0, resp_wait = 0, req_delay = 0, resp_delay = 0;
  bit resp_pend = 0, spurious = 0, prev_hold = 0;
  int done_cnt = 0, done_cyc = 0, valid_cycles = 0;
  mem_resp_t resp_word = '0;
  mem_req_t  prev_req = '0;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_00C3;
  endfunction

  function automatic logic [31:0] rsp_rd(input logic [31:0] a);
    return rsp_mem.exists(a) ? rsp_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Responder plus protocol monitor; everything happens on the falling edge.
  initial begin : agent
    txn_t t;
    forever begin
      @(negedge clk);
      if (rstn) begin
        chk("req_resp_exclusive", 128'(mem_req_valid & mem_resp_ready), 128'(0));
        if (prev_hold)
          chk("req_held_stable", 128'({mem_req_valid, mem_req}), 128'({1'b1, prev_req}));
        if (done_o) begin
          done_cnt++;
          done_cyc = cyc;
          chk("busy_low_at_done", 128'(busy_o), 128'(0));
        end
        if (mem_req_valid) valid_cycles++;

        if (resp_pend) begin
          if (resp_delay > 0) begin
            resp_delay--;
            mem_resp_valid = 1'b0;
          end else begin
            mem_resp_valid = 1'b1;
            mem_resp = resp_word;
          end
        end else begin
          mem_resp_valid = spurious;
          mem_resp.resp_data = $urandom;
          mem_resp.resp_last = 1'($urandom_range(0, 1));
        end
        if (mem_resp_valid && mem_resp_ready) resp_pend = 1'b0;

        if (mem_req_valid && !resp_pend) begin
          if (req_delay > 0) begin
            req_delay--;
            mem_req_ready = 1'b0;
          end else mem_req_ready = 1'b1;
        end else mem_req_ready = !mem_req_valid && ($urandom_range(0, 1) == 1);

        if (mem_req_valid && mem_req_ready) begin
          t.wr   = (mem_req.req_type == MEM_WRITE);
          t.addr = mem_req.req_addr;
          t.data = t.wr ? mem_req.req_data : 32'h0;
          t.mask = t.wr ? mem_req.req_mask : 4'h0;
          log_q.push_back(t);
          resp_pend  = 1'b1;
          resp_delay = resp_wait;
          req_delay  = req_wait;
          resp_word.resp_last = 1'($urandom_range(0, 1));
          if (t.wr) begin
            rsp_mem[t.addr] = t.data;
            resp_word.resp_data = $urandom;
          end else resp_word.resp_data = rsp_rd(t.addr);
        end
        prev_hold = mem_req_valid && !mem_req_ready;
        prev_req  = mem_req;
      end else begin
        resp_pend = 1'b0;
        mem_resp_valid = 1'b0;
        mem_req_ready = 1'b0;
        prev_hold = 1'b0;
        req_delay = req_wait;
      end
    end
  end

  task automatic run_copy(input string tag, input logic [31:0] src, input logic [31:0] dst,
                          input int len, input int rw, input int sw, input bit spur,
                          input int exp_lat, input int restart_at,
                          input bit fill, input logic [31:0] fdata);
    int start_cyc;
    int n;
    logic [31:0] d;
    logic [31:0] a;
    exp_q.delete();
    for (int i = 0; i < len; i++) begin
      a = src + 32'(4 * i);
      if (fill) d = fdata;
      else begin
        d = ref_rd(a);
        exp_q.push_back('{1'b0, a, 32'h0, 4'h0});
      end
      exp_q.push_back('{1'b1, dst + 32'(4 * i), d, 4'hF});
      ref_mem[dst + 32'(4 * i)] = d;
    end

    @(negedge clk); #1;
    log_q.delete();
    req_wait = rw; resp_wait = sw; req_delay = rw; spurious = spur; done_cnt = 0;
    src_addr_i = src; dst_addr_i = dst; len_i = 16'(len);
`ifdef DMA_FILL_EN
    fill_i = fill; fill_data_i = fdata;
`endif
    start_i = 1'b1;
    start_cyc = cyc;
    n = 0;
    while (done_cnt == 0 && n < exp_lat + 200) begin
      @(negedge clk); #1;
      n++;
      if (n == restart_at) begin
        start_i = 1'b1; src_addr_i = ~src; dst_addr_i = ~dst; len_i = 16'(len + 5);
      end else start_i = 1'b0;
    end
    chk({tag, "_done_seen"}, 128'(done_cnt > 0), 128'(1));
    chk({tag, "_latency"}, 128'(done_cyc - start_cyc), 128'(exp_lat));
    repeat (3) @(negedge clk);
    #1;
    spurious = 1'b0;
    chk({tag, "_single_done"}, 128'(done_cnt), 128'(1));
    chk({tag, "_idle_after"}, 128'({busy_o, mem_req_valid, mem_resp_ready}), 128'(0));
    chk({tag, "_txn_count"}, 128'(log_q.size()), 128'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      chk($sformatf("%s_txn%0d", tag, i), 128'(log_q[i]), 128'(exp_q[i]));
  endtask

  vec_t        tbl[6];
  logic [31:0] ord_addr[6];
  logic        ord_wr[6];

  initial begin
    tbl[0] = '{32'h0000_1000, 32'h0000_2000, 3, 0, 0, 1'b0, 14};
    tbl[1] = '{32'hFFFF_FFFC, 32'h0000_0100, 2, 0, 0, 1'b0, 10};
    tbl[2] = '{32'h0000_4000, 32'h0000_5000, 2, 5, 3, 1'b1, 42};
    tbl[3] = '{32'h0000_0010, 32'h0000_0014, 4, 1, 0, 1'b0, 26};
    tbl[4] = '{32'h0000_6000, 32'h0000_7000, 0, 0, 0, 1'b1, 2};
    tbl[5] = '{32'h0000_8000, 32'h0000_9000, 1, 0, 2, 1'b0, 10};
    ord_addr = '{32'h1000, 32'h2000, 32'h1004, 32'h2004, 32'h1008, 32'h2008};
    ord_wr   = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", 128'(busy_o), 128'(0));
    chk("rst_done", 128'(done_o), 128'(0));
    chk("rst_req_valid", 128'(mem_req_valid), 128'(0));
    chk("rst_resp_ready", 128'(mem_resp_ready), 128'(0));
    chk("rst_mem_req", 128'(mem_req), 128'(0));
    rstn = 1'b1;
    valid_cycles = 0;
    repeat (100) @(negedge clk);
    #1;
    chk("idle_no_request", 128'(valid_cycles), 128'(0));

    for (int v = 0; v < 6; v++) begin
      valid_cycles = 0;
      run_copy($sformatf("vec%0d", v), tbl[v].src, tbl[v].dst, tbl[v].len, tbl[v].rw,
               tbl[v].sw, tbl[v].spur, tbl[v].exp_lat, -1, 1'b0, 32'h0);
      if (v == 0) begin
        for (int k = 0; k < 6 && k < log_q.size(); k++)
          chk($sformatf("order%0d", k), 128'({log_q[k].wr, log_q[k].addr}),
              128'({ord_wr[k], ord_addr[k]}));
      end
      if (v == 1 && log_q.size() > 2) chk("wrap_second_read", 128'(log_q[2].addr), 128'(0));
      if (v == 4) chk("zero_len_no_valid", 128'(valid_cycles), 128'(0));
    end

    run_copy("restart", 32'h0000_C000, 32'h0000_D000, 3, 0, 1, 1'b0, 20, 4, 1'b0, 32'h0);

    // Asynchronous reset mid-copy abandons the transfer without a done pulse.
    @(negedge clk); #1;
    req_wait = 0; resp_wait = 1; req_delay = 0; done_cnt = 0;
    src_addr_i = 32'h0000_A000; dst_addr_i = 32'h0000_B000; len_i = 16'd6; start_i = 1'b1;
    @(negedge clk); #1;
    start_i = 1'b0;
    repeat (7) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("midrst_outputs", 128'({busy_o, done_o, mem_req_valid, mem_resp_ready}), 128'(0));
    chk("midrst_mem_req", 128'(mem_req), 128'(0));
    @(negedge clk); #1;
    rstn = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    chk("midrst_no_done", 128'(done_cnt), 128'(0));
    chk("midrst_idle", 128'({busy_o, mem_req_valid}), 128'(0));

    for (int r = 0; r < 8; r++) begin
      int len, rw, sw;
      logic [31:0] s, d;
      len = $urandom_range(1, 6);
      rw  = $urandom_range(0, 2);
      sw  = $urandom_range(0, 2);
      s   = 32'h1000_0000 | ($urandom & 32'h0FFF_FFFC);
      d   = 32'h1000_0000 | ($urandom & 32'h0FFF_FFFC);
      run_copy($sformatf("rand%0d", r), s, d, len, rw, sw, 1'($urandom_range(0, 1)),
               2 + len * (4 + 2 * rw + 2 * sw), -1, 1'b0, 32'h0);
    end

`ifdef DMA_FILL_EN
    begin
      int reads;
      run_copy("fill", 32'h0000_1000, 32'h0000_3000, 4, 0, 0, 1'b0, 10, -1, 1'b1, 32'hA5A5_A5A5);
      reads = 0;
      foreach (log_q[i]) if (!log_q[i].wr) reads++;
      chk("fill_no_reads", 128'(reads), 128'(0));
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
